// File: rtl/udp_seq_pkg.sv
// ---------------------------------------------------------------------------
// udp_seq_pkg
// Shared types and default sizing for the UDP frame sequencer.
//   seq_state_e : sequencer state (SYNC / PIXEL / LABEL)
//   digit_t     : one BCD digit of the distance label
//   *_DEF       : default parameter values used by the sequencer modules
// ---------------------------------------------------------------------------
package udp_seq_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    PIXEL = 2'd1,
    LABEL = 2'd2
  } seq_state_e;

  typedef logic [3:0] digit_t;

  localparam int PIXEL_PKTS_DEF   = 635;
  localparam int LABEL_SKIP_DEF   = 2;
  localparam int LABEL_DIGITS_DEF = 6;
  localparam int PKT_TIMEOUT_DEF  = 125000;

endpackage

// File: rtl/udp_label_capture.sv
// ---------------------------------------------------------------------------
// udp_label_capture
// Decodes the label packet of a frame into BCD distance digits.
//   i_clk      : clock
//   rst        : asynchronous active-high reset
//   i_clr      : holds the byte counter at 0 (sequencer not in LABEL)
//   i_en       : label byte valid this cycle
//   i_last     : current label byte is the last of the datagram
//   i_nibble   : low nibble of the current label byte
//   o_digits   : published digits, digit[0] in the MSBs, held between updates
//   o_update   : 1-cycle pulse the cycle after a complete label ends
//   o_err      : combinational, high on the last byte of an incomplete label
// ---------------------------------------------------------------------------
module udp_label_capture
  import udp_seq_pkg::*;
#(
  parameter int LABEL_SKIP   = LABEL_SKIP_DEF,
  parameter int LABEL_DIGITS = LABEL_DIGITS_DEF
) (
  input  logic                      i_clk,
  input  logic                      rst,
  input  logic                      i_clr,
  input  logic                      i_en,
  input  logic                      i_last,
  input  logic [3:0]                i_nibble,
  output logic [4*LABEL_DIGITS-1:0] o_digits,
  output logic                      o_update,
  output logic                      o_err
);

  localparam int BCNT_W = $clog2(LABEL_SKIP + LABEL_DIGITS + 1);
  // Counter saturates here; reaching COMPLETE_AT before the last byte means
  // the last byte itself makes the label long enough.
  localparam logic [BCNT_W-1:0] BCNT_MAX    = BCNT_W'(LABEL_SKIP + LABEL_DIGITS);
  localparam logic [BCNT_W-1:0] COMPLETE_AT = BCNT_W'(LABEL_SKIP + LABEL_DIGITS - 1);

  logic [BCNT_W-1:0]             bcnt_q;
  digit_t [LABEL_DIGITS-1:0]     shadow_q;
  digit_t [LABEL_DIGITS-1:0]     shadow_d;
  digit_t [LABEL_DIGITS-1:0]     digits_q;
  logic                          update_q;
  logic                          complete;

  // digit j lives at the MSB end: packed element LABEL_DIGITS-1-j
  for (genvar j = 0; j < LABEL_DIGITS; j++) begin : g_dig
    assign shadow_d[LABEL_DIGITS-1-j] =
      (i_en && (bcnt_q == BCNT_W'(LABEL_SKIP + j))) ? i_nibble
                                                    : shadow_q[LABEL_DIGITS-1-j];
  end

  assign complete = (bcnt_q >= COMPLETE_AT);
  assign o_err    = i_en & i_last & ~complete;
  assign o_digits = digits_q;
  assign o_update = update_q;

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      bcnt_q   <= '0;
      shadow_q <= '0;
      digits_q <= '0;
      update_q <= 1'b0;
    end else begin
      update_q <= 1'b0;
      shadow_q <= shadow_d;
      if (i_clr) begin
        bcnt_q <= '0;
      end else if (i_en) begin
        if (i_last) begin
          bcnt_q <= '0;
          // shadow_d already holds a digit carried by the last byte
          if (complete) begin
            digits_q <= shadow_d;
            update_q <= 1'b1;
          end
        end else if (bcnt_q != BCNT_MAX) begin
          bcnt_q <= bcnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/udp_frame_sequencer.sv
// ---------------------------------------------------------------------------
// udp_frame_sequencer
// Splits the UDP RX byte stream into video frames of PIXEL_PKTS pixel packets
// followed by one label packet. Pixel bytes are forwarded (1-cycle latency),
// the label is decoded into BCD digits, and stream faults force a resync.
//   i_clk / rst          : clock, asynchronous active-high reset
//   i_udp_rx_valid/data/last : RX byte stream (last qualified by valid)
//   o_pix_valid/data/last    : registered pixel byte stream
//   o_frame_start        : pulse with the first byte of packet 0
//   o_label_digits       : distance digits, digit[0] in MSBs
//   o_label_update       : pulse when o_label_digits refreshes
//   o_pkt_idx            : current packet index 0..PIXEL_PKTS
//   o_err_cnt            : saturating fault count
// Build option: define UDP_SEQ_TIMEOUT_EN to enable the mid-frame idle
// timeout (PKT_TIMEOUT cycles) that drops back to SYNC.
// ---------------------------------------------------------------------------
module udp_frame_sequencer
  import udp_seq_pkg::*;
#(
  parameter int PIXEL_PKTS   = PIXEL_PKTS_DEF,
  parameter int LABEL_SKIP   = LABEL_SKIP_DEF,
  parameter int LABEL_DIGITS = LABEL_DIGITS_DEF,
  parameter int PKT_TIMEOUT  = PKT_TIMEOUT_DEF
) (
  input  logic                      i_clk,
  input  logic                      rst,
  input  logic                      i_udp_rx_valid,
  input  logic [7:0]                i_udp_rx_data,
  input  logic                      i_udp_rx_last,
  output logic                      o_pix_valid,
  output logic [7:0]                o_pix_data,
  output logic                      o_pix_last,
  output logic                      o_frame_start,
  output logic [4*LABEL_DIGITS-1:0] o_label_digits,
  output logic                      o_label_update,
  output logic [9:0]                o_pkt_idx,
  output logic [7:0]                o_err_cnt
);

  localparam logic [9:0] LAST_PIX_IDX = 10'(PIXEL_PKTS - 1);
  localparam logic [9:0] LABEL_IDX    = 10'(PIXEL_PKTS);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  seq_state_e state_q;
  logic [9:0] pkt_idx_q;
  logic       mid_q;          // inside a datagram (a byte seen, no last yet)
  logic       pix_valid_q;
  logic [7:0] pix_data_q;
  logic       pix_last_q;
  logic       frame_start_q;
  logic [7:0] err_cnt_q;
  logic       rx_last;
  logic       lbl_err;
  logic       timeout;

  assign rx_last = i_udp_rx_valid & i_udp_rx_last;

`ifdef UDP_SEQ_TIMEOUT_EN
  localparam int IDLE_W = $clog2(PKT_TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_q;

  // A byte arriving on the expiry cycle still counts as activity.
  assign timeout = (state_q != SYNC) && !i_udp_rx_valid &&
                   (idle_q == IDLE_W'(PKT_TIMEOUT - 1));

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
    end else if ((state_q == SYNC) || i_udp_rx_valid || timeout) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + 1'b1;
    end
  end
`else
  // Timeout length has no effect when the idle counter is not built.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (PKT_TIMEOUT > 0);
  assign timeout = 1'b0;
`endif

  udp_label_capture #(
    .LABEL_SKIP  (LABEL_SKIP),
    .LABEL_DIGITS(LABEL_DIGITS)
  ) u_label (
    .i_clk   (i_clk),
    .rst     (rst),
    .i_clr   (state_q != LABEL),
    .i_en    ((state_q == LABEL) && i_udp_rx_valid),
    .i_last  (i_udp_rx_last),
    .i_nibble(i_udp_rx_data[3:0]),
    .o_digits(o_label_digits),
    .o_update(o_label_update),
    .o_err   (lbl_err)
  );

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state_q       <= SYNC;
      pkt_idx_q     <= '0;
      mid_q         <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      pix_last_q    <= 1'b0;
      frame_start_q <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      pix_valid_q   <= 1'b0;
      pix_last_q    <= 1'b0;
      frame_start_q <= 1'b0;
      if (i_udp_rx_valid) mid_q <= ~i_udp_rx_last;

      if (timeout) begin
        // cut the packet in progress; no o_pix_last is emitted
        state_q   <= SYNC;
        pkt_idx_q <= '0;
        mid_q     <= 1'b0;
        err_cnt_q <= sat_inc(err_cnt_q);
      end else begin
        case (state_q)
          SYNC: begin
            if (rx_last) begin
              state_q   <= PIXEL;
              pkt_idx_q <= '0;
            end
          end
          PIXEL: begin
            if (i_udp_rx_valid) begin
              pix_valid_q   <= 1'b1;
              pix_data_q    <= i_udp_rx_data;
              pix_last_q    <= i_udp_rx_last;
              frame_start_q <= (pkt_idx_q == '0) && !mid_q;
              if (i_udp_rx_last) begin
                if (pkt_idx_q == LAST_PIX_IDX) begin
                  pkt_idx_q <= LABEL_IDX;
                  state_q   <= LABEL;
                end else begin
                  pkt_idx_q <= pkt_idx_q + 10'd1;
                end
              end
            end
          end
          LABEL: begin
            if (rx_last) begin
              pkt_idx_q <= '0;
              state_q   <= PIXEL;
              if (lbl_err) err_cnt_q <= sat_inc(err_cnt_q);
            end
          end
          default: state_q <= SYNC;
        endcase
      end
    end
  end

  assign o_pix_valid   = pix_valid_q;
  assign o_pix_data    = pix_data_q;
  assign o_pix_last    = pix_last_q;
  assign o_frame_start = frame_start_q;
  assign o_pkt_idx     = pkt_idx_q;
  assign o_err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_udp_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_udp_frame_sequencer
// Directed bench for udp_frame_sequencer with PIXEL_PKTS=3, PKT_TIMEOUT=16.
// Timeout checks follow the UDP_SEQ_TIMEOUT_EN build option.
// ---------------------------------------------------------------------------
module tb_udp_frame_sequencer;

  localparam int PIX = 3;
  localparam int SKIP = 2;
  localparam int DIG = 6;
  localparam int TMO = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid;
  logic [7:0]       data;
  logic             last;
  logic             pix_valid;
  logic [7:0]       pix_data;
  logic             pix_last;
  logic             frame_start;
  logic [4*DIG-1:0] digits;
  logic             label_update;
  logic [9:0]       pkt_idx;
  logic [7:0]       err_cnt;

  int total = 0;
  int bad = 0;
  int pix_cnt = 0, last_cnt = 0, fs_cnt = 0, upd_cnt = 0;
  int s_pix, s_last, s_fs, s_upd;

  udp_frame_sequencer #(
    .PIXEL_PKTS(PIX), .LABEL_SKIP(SKIP), .LABEL_DIGITS(DIG), .PKT_TIMEOUT(TMO)
  ) dut (
    .i_clk(clk), .rst(rst),
    .i_udp_rx_valid(valid), .i_udp_rx_data(data), .i_udp_rx_last(last),
    .o_pix_valid(pix_valid), .o_pix_data(pix_data), .o_pix_last(pix_last),
    .o_frame_start(frame_start), .o_label_digits(digits),
    .o_label_update(label_update), .o_pkt_idx(pkt_idx), .o_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pix_valid) pix_cnt++;
    if (pix_valid && pix_last) last_cnt++;
    if (frame_start) fs_cnt++;
    if (label_update) upd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive one byte (called at a negedge); returns at the next negedge
  task automatic put(input logic [7:0] d, input logic l);
    valid = 1'b1; data = d; last = l;
    @(negedge clk);
  endtask

  task automatic gap(input int n);
    valid = 1'b0; last = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // send the low n bytes of w, most significant first, last on the final one
  task automatic send_word(input logic [79:0] w, input int n);
    for (int i = 0; i < n; i++) put(w[8*(n-1-i) +: 8], i == n - 1);
  endtask

  task automatic pix_frame(input int nb, input logic [7:0] base);
    for (int p = 0; p < PIX; p++) begin
      for (int b = 0; b < nb; b++) put(8'(base + p*16 + b), b == nb - 1);
      gap(1);
    end
  endtask

  task automatic snap();
    #1;
    s_pix = pix_cnt; s_last = last_cnt; s_fs = fs_cnt; s_upd = upd_cnt;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; data = '0; last = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_pix_data", 32'(pix_data), 32'd0);
    chk("rst_pix_last", 32'(pix_last), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_digits", 32'(digits), 32'd0);
    chk("rst_update", 32'(label_update), 32'd0);
    chk("rst_idx", 32'(pkt_idx), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    gap(1);

    // junk packet is dropped in SYNC
    send_word(80'hAABBCC, 3);
    gap(1);
    #1;
    chk("junk_drop", 32'(pix_cnt), 32'd0);
    chk("junk_idx", 32'(pkt_idx), 32'd0);

    // frame 1: first byte latency and frame start
    put(8'h10, 1'b0);
    chk("first_valid", 32'(pix_valid), 32'd1);
    chk("first_data", 32'(pix_data), 32'h10);
    chk("first_fs", 32'(frame_start), 32'd1);
    put(8'h11, 1'b0);
    chk("second_fs", 32'(frame_start), 32'd0);
    put(8'h12, 1'b0);
    put(8'h13, 1'b1);
    chk("pkt0_last", 32'(pix_last), 32'd1);
    chk("pkt0_idx", 32'(pkt_idx), 32'd1);
    gap(1);
    send_word(80'h20212223, 4); gap(1);
    send_word(80'h30313233, 4); gap(1);
    chk("label_idx", 32'(pkt_idx), 32'd3);
    #1;
    chk("f1_pix_n", 32'(pix_cnt), 32'd12);
    chk("f1_last_n", 32'(last_cnt), 32'd3);
    chk("f1_fs_n", 32'(fs_cnt), 32'd1);
    send_word(80'h0000313233343536, 8);
    chk("f1_update", 32'(label_update), 32'd1);
    chk("f1_digits", 32'(digits), 32'h123456);
    chk("f1_idx_wrap", 32'(pkt_idx), 32'd0);
    chk("f1_label_nopix", 32'(pix_valid), 32'd0);
    gap(1);
    chk("f1_update_pulse", 32'(label_update), 32'd0);
    #1;
    chk("f1_upd_n", 32'(upd_cnt), 32'd1);

    // frame 2: short label -> error, digits held
    snap();
    pix_frame(4, 8'h40);
    send_word(80'h00003738, 4);
    chk("short_update", 32'(label_update), 32'd0);
    chk("short_digits", 32'(digits), 32'h123456);
    chk("short_err", 32'(err_cnt), 32'd1);
    chk("short_idx", 32'(pkt_idx), 32'd0);
    gap(1);

    // frame 3: normal pixels, long label keeps the first six digits
    pix_frame(4, 8'h50);
    #1;
    chk("f3_pix_n", 32'(pix_cnt - s_pix), 32'd24);
    chk("f3_fs_n", 32'(fs_cnt - s_fs), 32'd2);
    send_word(80'h00003938373635343332, 10);
    chk("long_update", 32'(label_update), 32'd1);
    chk("long_digits", 32'(digits), 32'h987654);
    chk("long_err", 32'(err_cnt), 32'd1);
    gap(1);
    #1;
    chk("f23_upd_n", 32'(upd_cnt - s_upd), 32'd1);

    // frame 4: single-byte pixel packets
    put(8'h70, 1'b1);
    chk("sb0_valid", 32'(pix_valid), 32'd1);
    chk("sb0_last", 32'(pix_last), 32'd1);
    chk("sb0_fs", 32'(frame_start), 32'd1);
    chk("sb0_idx", 32'(pkt_idx), 32'd1);
    put(8'h71, 1'b1);
    chk("sb1_last", 32'(pix_last), 32'd1);
    chk("sb1_fs", 32'(frame_start), 32'd0);
    chk("sb1_idx", 32'(pkt_idx), 32'd2);
    put(8'h72, 1'b1);
    chk("sb2_data", 32'(pix_data), 32'h72);
    chk("sb2_idx", 32'(pkt_idx), 32'd3);
    send_word(80'h0000313131313131, 8);
    chk("sb_digits", 32'(digits), 32'h111111);
    gap(1);

    // frame 5: stall inside packet 1
    send_word(80'h80818283, 4);
    gap(1);
    chk("st_idx", 32'(pkt_idx), 32'd1);
    put(8'h84, 1'b0);
    put(8'h85, 1'b0);
    gap(0);
    snap();
    gap(20);
    #1;
`ifdef UDP_SEQ_TIMEOUT_EN
    chk("to_err", 32'(err_cnt), 32'd2);
    chk("to_idx", 32'(pkt_idx), 32'd0);
    chk("to_no_last", 32'(last_cnt - s_last), 32'd0);
    snap();
    send_word(80'h90919293, 4);
    gap(1);
    #1;
    chk("to_drop", 32'(pix_cnt - s_pix), 32'd0);
    put(8'hA0, 1'b0);
    chk("to_fs", 32'(frame_start), 32'd1);
    chk("to_data", 32'(pix_data), 32'hA0);
    put(8'hA1, 1'b0);
    put(8'hA2, 1'b1);
    chk("to_idx1", 32'(pkt_idx), 32'd1);
    gap(1);
    send_word(80'hB0B1, 2); gap(1);
    send_word(80'hB2B3, 2); gap(1);
`else
    chk("wait_err", 32'(err_cnt), 32'd1);
    chk("wait_idx", 32'(pkt_idx), 32'd1);
    put(8'h86, 1'b1);
    chk("wait_last", 32'(pix_last), 32'd1);
    chk("wait_idx2", 32'(pkt_idx), 32'd2);
    gap(1);
    send_word(80'hB2B3, 2); gap(1);
`endif
    chk("pre_rst_idx", 32'(pkt_idx), 32'd3);

    // reset in the middle of the label packet
    put(8'h00, 1'b0);
    put(8'h00, 1'b0);
    put(8'h31, 1'b0);
    rst = 1'b1;
    #1;
    chk("mr_pix_valid", 32'(pix_valid), 32'd0);
    chk("mr_digits", 32'(digits), 32'd0);
    chk("mr_idx", 32'(pkt_idx), 32'd0);
    chk("mr_err", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_word(80'h3233, 2);   // tail of the interrupted label, eaten by SYNC
    gap(1);
    snap();
    chk("mr_sync_idx", 32'(pkt_idx), 32'd0);
    pix_frame(4, 8'hC0);
    send_word(80'h0000313233343536, 8);
    chk("mr_digits2", 32'(digits), 32'h123456);
    chk("mr_update", 32'(label_update), 32'd1);
    gap(1);
    #1;
    chk("mr_pix_n", 32'(pix_cnt - s_pix), 32'd12);
    chk("mr_fs_n", 32'(fs_cnt - s_fs), 32'd1);

    // 300 one-byte labels, each an incomplete label fault
    for (int k = 0; k < 300; k++) begin
      for (int p = 0; p < PIX; p++) put(8'(k), 1'b1);
      put(8'h00, 1'b1);
      if (k == 9) chk("sat_err10", 32'(err_cnt), 32'd10);
      if (k == 254) chk("sat_err255", 32'(err_cnt), 32'd255);
    end
    gap(1);
    chk("sat_err", 32'(err_cnt), 32'hFF);
    chk("sat_digits", 32'(digits), 32'h123456);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
